alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational CPU ALU.
- Adds a valid/ready handshake and a persistent flag register (Z, C, N, V).
- Adds an iterative unsigned multiplier plus ASR, ROR and ORR micro-ops.
- Sits between the decode/operand-fetch stage and writeback; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of two).
- UOP_W, 5, micro-op field width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and uop are valid.
- in_ready  output  1  block can accept an operation.
- lhs  input  WIDTH  left-hand operand.
- rhs  input  WIDTH  right-hand operand or shift amount.
- uop  input  UOP_W  micro-operation.
- out_valid  output  1  result is valid; held until out_ready.
- out_ready  input  1  consumer takes the result.
- out_alu  output  WIDTH  registered result.
- flags_out  output  4  registered flags: [0]=Z, [1]=C, [2]=N, [3]=V.

Behaviour:
- Reset: one clock, synchronous, active-high. Clears state to IDLE, out_alu=0, flags_out=0, out_valid=0; in_ready=1 from the next cycle. Reset mid-operation aborts the multiply and discards the pending result; flags are cleared.
- States:
  - IDLE: in_ready=1.
  - BUSY: multiply iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Accept occurs when in_valid & in_ready on a clock edge; lhs, rhs and uop are captured.
- Single-cycle ops: IDLE→DONE. out_valid rises the cycle after accept (latency 1).
- MUL: IDLE→BUSY for exactly WIDTH cycles, one shift-add step per cycle, then DONE (latency WIDTH+1).
- DONE→IDLE on out_ready. Otherwise out_alu and flags_out hold stable. At most one op is in flight; there is no back-to-back accept from DONE.
- uop encoding and results:
  - 0 NOP: result 0.
  - 1 ADD: lhs+rhs.
  - 2 SUB: lhs-rhs.
  - 3 AND.
  - 4 XOR.
  - 5 CMP: result lhs-rhs, delivered but ignored by writeback.
  - 6 LSL.
  - 7 LSR.
  - 8 MOV: result rhs.
  - 9 STR, 10 LDR: address = lhs+rhs.
  - 11 MUL: low WIDTH bits of unsigned lhs*rhs.
  - 12 ASR.
  - 13 ROR.
  - 14 ORR.
  - 15..31: treated as NOP.
- Shifts use the full rhs value:
  - LSL/LSR with rhs≥WIDTH give 0.
  - ASR with rhs≥WIDTH gives all bits equal to lhs[WIDTH-1].
  - ROR rotates by rhs mod WIDTH.
  - A shift of 0 returns lhs unchanged.
- Flag update happens at the DONE transition, only for uops 1–8 and 11–14. NOP, STR, LDR and undefined uops leave all four flags unchanged.
- Z and N: Z = (result==0), N = result[WIDTH-1].
- C by op:
  - ADD: carry out of the WIDTH+1-bit unsigned sum.
  - SUB/CMP: bit WIDTH of the zero-extended difference (1 = borrow).
  - LSL: the last bit shifted out, lhs[WIDTH-rhs] for 1≤rhs≤WIDTH, else 0.
  - MUL: 1 if the upper WIDTH product bits are nonzero.
  - All others: 0.
- V by op:
  - ADD: (lhs[MSB]==rhs[MSB]) & (res[MSB]!=lhs[MSB]).
  - SUB/CMP: (lhs[MSB]!=rhs[MSB]) & (res[MSB]!=lhs[MSB]).
  - All others: 0.
- Input changes while busy are ignored; operands are taken only from the accept-cycle capture.
- Multiplier internals: 2*WIDTH accumulator plus a shifted multiplicand, with a counter of $clog2(WIDTH)+1 bits.

Test Plan:
- Reset, then ADD lhs=0xFFFFFFFF, rhs=1 → out_valid one cycle after accept, out_alu=0, Z=1, C=1, N=0, V=0.
- SUB 0x80000000−1 → out_alu=0x7FFFFFFF, V=1, C=0, N=0. Follow with NOP → flags unchanged.
- MUL 0x00010000×0x00010000 (WIDTH=32) → out_valid exactly 33 cycles after accept, out_alu=0, C=1, Z=1. Then MUL 7×6 → 42, C=0.
- Shifts:
  - ASR 0x80000000 by 40 → 0xFFFFFFFF, N=1.
  - ROR 0x00000001 by 33 → 0x80000000.
  - LSL 0x80000001 by 1 → 0x00000002, C=1.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid, out_alu and flags stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready → IDLE next cycle.
- Assert rst at cycle 10 of a MUL → next cycle state IDLE, out_valid=0, flags_out=0, no result delivered. Rerun with WIDTH=8: 0xFF+0x01 → 0x00, C=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent Z/C/N/V flags and an
// iterative shift-add unsigned multiplier.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int UOP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic [UOP_W-1:0] uop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic [3:0]       flags_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [UOP_W-1:0] {
    UOP_NOP = UOP_W'(0),
    UOP_ADD = UOP_W'(1),
    UOP_SUB = UOP_W'(2),
    UOP_AND = UOP_W'(3),
    UOP_XOR = UOP_W'(4),
    UOP_CMP = UOP_W'(5),
    UOP_LSL = UOP_W'(6),
    UOP_LSR = UOP_W'(7),
    UOP_MOV = UOP_W'(8),
    UOP_STR = UOP_W'(9),
    UOP_LDR = UOP_W'(10),
    UOP_MUL = UOP_W'(11),
    UOP_ASR = UOP_W'(12),
    UOP_ROR = UOP_W'(13),
    UOP_ORR = UOP_W'(14)
  } uop_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_alu_q, out_alu_d;
  logic [3:0]           flags_q, flags_d;

  logic [WIDTH:0]       sum_c, diff_c, lsl_ext_c;
  logic [WIDTH-1:0]     res_c;
  logic                 c_c, v_c, upd_c, big_sh_c;
  logic [2*WIDTH-1:0]   acc_step;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_alu   = out_alu_q;
  assign flags_out = flags_q;

  // Single-cycle ops are evaluated on the live operands and registered on the
  // accept edge, which is equivalent to capturing them first.
  always_comb begin
    sum_c     = {1'b0, lhs} + {1'b0, rhs};
    diff_c    = {1'b0, lhs} - {1'b0, rhs};
    lsl_ext_c = {1'b0, lhs} << rhs;
    big_sh_c  = (rhs >= W_VAL);
    res_c     = '0;
    c_c       = 1'b0;
    v_c       = 1'b0;
    upd_c     = 1'b1;
    case (uop)
      UOP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (lhs[WIDTH-1] == rhs[WIDTH-1]) & (sum_c[WIDTH-1] != lhs[WIDTH-1]);
      end
      UOP_SUB, UOP_CMP: begin
        res_c = diff_c[WIDTH-1:0];
        c_c   = diff_c[WIDTH];
        v_c   = (lhs[WIDTH-1] != rhs[WIDTH-1]) & (diff_c[WIDTH-1] != lhs[WIDTH-1]);
      end
      UOP_AND: res_c = lhs & rhs;
      UOP_XOR: res_c = lhs ^ rhs;
      UOP_ORR: res_c = lhs | rhs;
      UOP_MOV: res_c = rhs;
      UOP_LSL: begin
        res_c = lsl_ext_c[WIDTH-1:0];
        c_c   = lsl_ext_c[WIDTH];
      end
      UOP_LSR: res_c = big_sh_c ? '0 : (lhs >> rhs);
      UOP_ASR: res_c = big_sh_c ? {WIDTH{lhs[WIDTH-1]}} : WIDTH'($signed(lhs) >>> rhs);
      UOP_ROR: res_c = WIDTH'({lhs, lhs} >> rhs[SH_W-1:0]);
      UOP_STR, UOP_LDR: begin
        res_c = sum_c[WIDTH-1:0];
        upd_c = 1'b0;
      end
      default: upd_c = 1'b0;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    out_alu_d = out_alu_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (uop == UOP_MUL) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, lhs};
            mplier_d = rhs;
            cnt_d    = '0;
          end else begin
            state_d   = S_DONE;
            out_alu_d = res_c;
            if (upd_c) begin
              flags_d = {v_c, res_c[WIDTH-1], c_c, (res_c == '0)};
            end
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          state_d   = S_DONE;
          out_alu_d = acc_step[WIDTH-1:0];
          flags_d   = {1'b0, acc_step[WIDTH-1], (acc_step[2*WIDTH-1:WIDTH] != '0),
                       (acc_step[WIDTH-1:0] == '0)};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      out_alu_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      out_alu_q <= out_alu_d;
      flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven checks of alu_seq (WIDTH=32) plus a WIDTH=8 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] lhs, rhs, out_alu;
  logic [4:0]  uop;
  logic [3:0]  flags_out;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  lhs8, rhs8, out_alu8;
  logic [4:0]  uop8;
  logic [3:0]  flags8;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .UOP_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .uop(uop), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .flags_out(flags_out)
  );

  alu_seq #(.WIDTH(8), .UOP_W(5)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .lhs(lhs8), .rhs(rhs8), .uop(uop8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_alu(out_alu8), .flags_out(flags8)
  );

  typedef struct {
    logic [4:0]  u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] u, input logic [31:0] a, b, res,
                         input logic [3:0] fl, input int lat);
    vec_t v;
    v.u = u; v.a = a; v.b = b; v.res = res; v.fl = fl; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op on the 32-bit instance, scramble inputs after accept, wait for
  // the result (bounded), then retire it.
  task automatic run_op(input logic [4:0] u, input logic [31:0] a, b,
                        output logic [31:0] res, output logic [3:0] fl, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1; uop = u; lhs = a; rhs = b;
    @(posedge clk); #1;
    in_valid = 1'b0; uop = 5'd11; lhs = 32'hDEADBEEF; rhs = 32'h0BADF00D;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_alu;
    fl  = flags_out;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, seen;

    // uop, lhs, rhs, result, flags {V,N,C,Z}, latency
    add_vec(5'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0011, 1);
    add_vec(5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1000, 1);
    add_vec(5'd0,  32'h00000005, 32'h00000006, 32'h00000000, 4'b1000, 1);
    add_vec(5'd11, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0011, 33);
    add_vec(5'd11, 32'h00000007, 32'h00000006, 32'h0000002A, 4'b0000, 33);
    add_vec(5'd12, 32'h80000000, 32'd40,       32'hFFFFFFFF, 4'b0100, 1);
    add_vec(5'd13, 32'h00000001, 32'd33,       32'h80000000, 4'b0100, 1);
    add_vec(5'd6,  32'h80000001, 32'd1,        32'h00000002, 4'b0010, 1);
    add_vec(5'd9,  32'h00000100, 32'h00000024, 32'h00000124, 4'b0010, 1);
    add_vec(5'd3,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0001, 1);
    add_vec(5'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 1);
    add_vec(5'd5,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110, 1);
    add_vec(5'd7,  32'h80000000, 32'd31,       32'h00000001, 4'b0000, 1);
    add_vec(5'd7,  32'hFFFFFFFF, 32'd32,       32'h00000000, 4'b0001, 1);
    add_vec(5'd8,  32'h12345678, 32'h80000000, 32'h80000000, 4'b0100, 1);
    add_vec(5'd14, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 4'b0000, 1);
    add_vec(5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1100, 1);
    add_vec(5'd20, 32'h00000003, 32'h00000004, 32'h00000000, 4'b1100, 1);
    add_vec(5'd10, 32'hFFFFFFF0, 32'h00000020, 32'h00000010, 4'b1100, 1);
    add_vec(5'd6,  32'h12345678, 32'd0,        32'h12345678, 4'b0000, 1);
    add_vec(5'd12, 32'h40000000, 32'd40,       32'h00000000, 4'b0001, 1);
    add_vec(5'd13, 32'h12345678, 32'd32,       32'h12345678, 4'b0000, 1);
    add_vec(5'd6,  32'h00000001, 32'd32,       32'h00000000, 4'b0011, 1);
    add_vec(5'd12, 32'h80000000, 32'd4,        32'hF8000000, 4'b0100, 1);
    add_vec(5'd11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0110, 33);
    add_vec(5'd2,  32'h00000003, 32'h00000003, 32'h00000000, 4'b0001, 1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lhs = '0; rhs = '0; uop = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; lhs8 = '0; rhs8 = '0; uop8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready",    32'(in_ready),   32'd1);
    chk("reset out_valid",   32'(out_valid),  32'd0);
    chk("reset out_alu",     out_alu,         32'd0);
    chk("reset flags",       32'(flags_out),  32'd0);
    chk("reset8 in_ready",   32'(in_ready8),  32'd1);
    chk("reset8 out_valid",  32'(out_valid8), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].u, vecs[i].a, vecs[i].b, r, f, lat);
      chk($sformatf("vec%0d result", i),  r,        vecs[i].res);
      chk($sformatf("vec%0d flags", i),   32'(f),   32'(vecs[i].fl));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: ADD 2+3 held in DONE while a competing request is offered.
    @(negedge clk);
    in_valid = 1'b1; uop = 5'd1; lhs = 32'd2; rhs = 32'd3;
    @(posedge clk); #1;
    uop = 5'd2; lhs = 32'd9; rhs = 32'd1;
    chk("bp out_valid first", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_alu",   out_alu,        32'd5);
      chk("bp flags",     32'(flags_out), 32'd0);
      chk("bp in_ready",  32'(in_ready),  32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready",  32'(in_ready),  32'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp no extra accept", 32'(seen), 32'd0);

    // Reset during the tenth busy cycle of a multiply.
    run_op(5'd2, 32'd0, 32'd1, r, f, lat);
    chk("pre-reset result", r,      32'hFFFFFFFF);
    chk("pre-reset flags",  32'(f), 32'b0110);
    @(negedge clk);
    in_valid = 1'b1; uop = 5'd11; lhs = 32'h00001234; rhs = 32'h00005678;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mul busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready",  32'(in_ready),  32'd1);
    chk("abort flags",     32'(flags_out), 32'd0);
    chk("abort out_alu",   out_alu,        32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no result", 32'(seen), 32'd0);

    // WIDTH=8 instance.
    @(negedge clk);
    in_valid8 = 1'b1; uop8 = 5'd1; lhs8 = 8'hFF; rhs8 = 8'h01;
    @(posedge clk); #1; in_valid8 = 1'b0;
    chk("w8 add out_valid", 32'(out_valid8), 32'd1);
    chk("w8 add result",    32'(out_alu8),   32'h00);
    chk("w8 add flags",     32'(flags8),     32'b0011);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b1; uop8 = 5'd11; lhs8 = 8'h10; rhs8 = 8'h10;
    @(posedge clk); #1; in_valid8 = 1'b0; lhs8 = 8'h55; rhs8 = 8'hAA;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8 mul latency", 32'(lat),       32'd9);
    chk("w8 mul result",  32'(out_alu8),  32'h00);
    chk("w8 mul flags",   32'(flags8),    32'b0011);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    chk("w8 mul retire", 32'(in_ready8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
